// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage branch hazard logic.
package hazard_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STALL_W = 4;

    localparam int unsigned DEF_ALU_STALLS      = 1;
    localparam int unsigned DEF_LOAD_EX_STALLS  = 2;
    localparam int unsigned DEF_LOAD_MEM_STALLS = 1;
    localparam int unsigned DEF_CNT_W           = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // $0 is hard-wired, so it can never be a hazard or forward source.
    function automatic logic reg_match(input logic [REG_W-1:0] r, input logic [REG_W-1:0] d);
        return (r != '0) && (r == d);
    endfunction

endpackage

// File: rtl/branch_operand_ctrl_hazard_detect.sv
// Combinational hazard check for the ID-stage branch: operand forward selects
// and the number of stall cycles the branch needs before it can compare.
module branch_hazard_detect
    import hazard_pkg::*;
#(
    parameter int unsigned ALU_STALLS      = DEF_ALU_STALLS,
    parameter int unsigned LOAD_EX_STALLS  = DEF_LOAD_EX_STALLS,
    parameter int unsigned LOAD_MEM_STALLS = DEF_LOAD_MEM_STALLS
) (
    input  logic               id_branch,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               ex_regwrite,
    input  logic               ex_memtoreg,
    input  logic [REG_W-1:0]   ex_rd,
    input  logic               mem_regwrite,
    input  logic               mem_memtoreg,
    input  logic [REG_W-1:0]   mem_rd,
    output logic               fwd_a,
    output logic               fwd_b,
    output logic [STALL_W-1:0] need
);

    logic               w_ex_hit;
    logic               w_mem_hit;
    logic [STALL_W-1:0] w_ex_need;
    logic [STALL_W-1:0] w_mem_need;

    assign w_ex_hit  = reg_match(id_rs, ex_rd)  || reg_match(id_rt, ex_rd);
    assign w_mem_hit = reg_match(id_rs, mem_rd) || reg_match(id_rt, mem_rd);

    // Only an ALU result parked in EX/MEM can be forwarded; a load's data is not ready yet.
    assign fwd_a = mem_regwrite && !mem_memtoreg && reg_match(id_rs, mem_rd);
    assign fwd_b = mem_regwrite && !mem_memtoreg && reg_match(id_rt, mem_rd);

    always_comb begin
        w_ex_need  = '0;
        w_mem_need = '0;
        need       = '0;
        if (ex_regwrite && w_ex_hit) begin
            w_ex_need = ex_memtoreg ? STALL_W'(LOAD_EX_STALLS) : STALL_W'(ALU_STALLS);
        end
        if (mem_regwrite && mem_memtoreg && w_mem_hit) begin
            w_mem_need = STALL_W'(LOAD_MEM_STALLS);
        end
        if (id_branch) begin
            need = (w_ex_need > w_mem_need) ? w_ex_need : w_mem_need;
        end
    end

endmodule

// File: rtl/branch_operand_ctrl.sv
// ID-stage branch controller: drives comparator operand muxes, sequences
// branch stalls, resolves pc_src, and counts stall cycles.
module branch_operand_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned ALU_STALLS      = DEF_ALU_STALLS,
    parameter int unsigned LOAD_EX_STALLS  = DEF_LOAD_EX_STALLS,
    parameter int unsigned LOAD_MEM_STALLS = DEF_LOAD_MEM_STALLS,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_branch,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             cmp_eq,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             stall,
    output logic             flush_ex,
    output logic             cmp_valid,
    output logic             pc_src,
    output logic             flush_if,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [STALL_W-1:0] r_cnt;
    logic [STALL_W-1:0] w_next_cnt;
    logic [STALL_W-1:0] w_need;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic               w_stall;
    logic               w_cmp_valid;
    logic               w_pc_src;

    branch_hazard_detect #(
        .ALU_STALLS      (ALU_STALLS),
        .LOAD_EX_STALLS  (LOAD_EX_STALLS),
        .LOAD_MEM_STALLS (LOAD_MEM_STALLS)
    ) u_detect (
        .id_branch    (id_branch),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_rd       (mem_rd),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .need         (w_need)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next state and Mealy outputs; a stall always masks resolution.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_cmp_valid  = 1'b0;
        w_pc_src     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_need != '0) begin
                    w_stall      = 1'b1;
                    w_next_cnt   = STALL_W'(w_need - STALL_W'(1));
                    w_next_state = (w_need > STALL_W'(1)) ? ST_STALL : ST_IDLE;
                end else if (id_branch) begin
                    w_cmp_valid = 1'b1;
                    w_pc_src    = cmp_eq ^ id_bne;
                end
            end
            ST_STALL: begin
                w_stall    = 1'b1;
                w_next_cnt = STALL_W'(r_cnt - STALL_W'(1));
                if (r_cnt <= STALL_W'(1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall        = w_stall;
    assign flush_ex     = w_stall;
    assign cmp_valid    = w_cmp_valid;
    assign pc_src       = w_pc_src;
    assign flush_if     = w_pc_src;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_branch_operand_ctrl.sv
// Directed bench for branch_operand_ctrl with hand-computed expectations.
module tb_branch_operand_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             id_branch;
    logic             id_bne;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic [4:0]       ex_rd;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic [4:0]       mem_rd;
    logic             cmp_eq;
    logic             fwd_a;
    logic             fwd_b;
    logic             stall;
    logic             flush_ex;
    logic             cmp_valid;
    logic             pc_src;
    logic             flush_if;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks;
    int n_errors;

    branch_operand_ctrl #(
        .ALU_STALLS      (1),
        .LOAD_EX_STALLS  (2),
        .LOAD_MEM_STALLS (1),
        .CNT_W           (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_branch    (id_branch),
        .id_bne       (id_bne),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_rd       (mem_rd),
        .cmp_eq       (cmp_eq),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .flush_ex     (flush_ex),
        .cmp_valid    (cmp_valid),
        .pc_src       (pc_src),
        .flush_if     (flush_if),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        ex_regwrite  = 1'b0;
        ex_memtoreg  = 1'b0;
        ex_rd        = 5'd0;
        mem_regwrite = 1'b0;
        mem_memtoreg = 1'b0;
        mem_rd       = 5'd0;
    endtask

    task automatic check_resolved(input string tag, input logic exp_pc);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd1);
        check_eq({tag, "_pc_src"}, 32'(pc_src), 32'(exp_pc));
        check_eq({tag, "_flush_if"}, 32'(flush_if), 32'(exp_pc));
    endtask

    task automatic check_stalled(input string tag, input logic [31:0] exp_cycles);
        check_eq({tag, "_stall"}, 32'(stall), 32'd1);
        check_eq({tag, "_flush_ex"}, 32'(flush_ex), 32'd1);
        check_eq({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd0);
        check_eq({tag, "_pc_src"}, 32'(pc_src), 32'd0);
        check_eq({tag, "_flush_if"}, 32'(flush_if), 32'd0);
        check_eq({tag, "_cycles"}, 32'(stall_cycles), exp_cycles);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        id_branch = 1'b0;
        id_bne    = 1'b0;
        id_rs     = 5'd0;
        id_rt     = 5'd0;
        cmp_eq    = 1'b0;
        clear_pipe();
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check_eq("rst_pc_src", 32'(pc_src), 32'd0);
        check_eq("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check_eq("rst_cycles", 32'(stall_cycles), 32'd0);

        // Reset held two cycles while a load-in-EX stall is in progress.
        tick();
        id_branch   = 1'b1;
        id_rs       = 5'd8;
        id_rt       = 5'd1;
        ex_regwrite = 1'b1;
        ex_memtoreg = 1'b1;
        ex_rd       = 5'd8;
        #2;
        check_stalled("rstst_c0", 32'd0);
        tick();
        #2;
        check_stalled("rstst_c1", 32'd1);
        reset = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        id_branch = 1'b0;
        clear_pipe();
        #2;
        check_eq("rstst_stall", 32'(stall), 32'd0);
        check_eq("rstst_cycles", 32'(stall_cycles), 32'd0);
        check_eq("rstst_cmp_valid", 32'(cmp_valid), 32'd0);

        // beq/bne with no hazard resolve in the same cycle.
        tick();
        id_branch = 1'b1;
        id_rs     = 5'd3;
        id_rt     = 5'd4;
        cmp_eq    = 1'b1;
        #2;
        check_resolved("beq_taken", 1'b1);
        id_bne = 1'b1;
        #1;
        check_resolved("bne_eq", 1'b0);
        cmp_eq = 1'b0;
        #1;
        check_resolved("bne_ne", 1'b1);

        // ALU producer in EX -> one stall, then forwarded from MEM.
        tick();
        id_bne      = 1'b0;
        id_rt       = 5'd5;
        ex_regwrite = 1'b1;
        ex_rd       = 5'd5;
        #2;
        check_stalled("alu_c0", 32'd0);
        tick();
        clear_pipe();
        mem_regwrite = 1'b1;
        mem_rd       = 5'd5;
        cmp_eq       = 1'b1;
        #2;
        check_eq("alu_fwd_b", 32'(fwd_b), 32'd1);
        check_eq("alu_fwd_a", 32'(fwd_a), 32'd0);
        check_resolved("alu_res", 1'b1);
        check_eq("alu_cycles", 32'(stall_cycles), 32'd1);

        // Load in EX -> two stalls; load then in MEM -> residual stall; then resolve.
        tick();
        clear_pipe();
        id_rs       = 5'd9;
        id_rt       = 5'd2;
        ex_regwrite = 1'b1;
        ex_memtoreg = 1'b1;
        ex_rd       = 5'd9;
        #2;
        check_stalled("ld_c0", 32'd1);
        tick();
        #2;
        check_stalled("ld_c1", 32'd2);
        tick();
        clear_pipe();
        mem_regwrite = 1'b1;
        mem_memtoreg = 1'b1;
        mem_rd       = 5'd9;
        #2;
        check_stalled("ld_resid", 32'd3);
        check_eq("ld_resid_fwd_a", 32'(fwd_a), 32'd0);
        tick();
        clear_pipe();
        cmp_eq = 1'b0;
        #2;
        check_resolved("ld_res", 1'b0);
        check_eq("ld_fwd_a", 32'(fwd_a), 32'd0);
        check_eq("ld_cycles", 32'(stall_cycles), 32'd4);

        // $0 never hazards or forwards.
        tick();
        id_rs        = 5'd0;
        id_rt        = 5'd7;
        ex_regwrite  = 1'b1;
        ex_rd        = 5'd0;
        mem_regwrite = 1'b1;
        mem_rd       = 5'd0;
        cmp_eq       = 1'b1;
        #2;
        check_resolved("r0", 1'b1);
        check_eq("r0_fwd_a", 32'(fwd_a), 32'd0);

        // Load in EX on rs plus ALU in MEM on rt -> N=2, forward select live throughout.
        tick();
        clear_pipe();
        id_rs        = 5'd10;
        id_rt        = 5'd11;
        ex_regwrite  = 1'b1;
        ex_memtoreg  = 1'b1;
        ex_rd        = 5'd10;
        mem_regwrite = 1'b1;
        mem_rd       = 5'd11;
        #2;
        check_stalled("mix_c0", 32'd4);
        check_eq("mix_c0_fwd_b", 32'(fwd_b), 32'd1);
        tick();
        #2;
        check_stalled("mix_c1", 32'd5);
        tick();
        ex_regwrite = 1'b0;
        ex_memtoreg = 1'b0;
        ex_rd       = 5'd0;
        #2;
        check_resolved("mix_res", 1'b1);
        check_eq("mix_fwd_b", 32'(fwd_b), 32'd1);
        mem_rd = 5'd12;
        #1;
        check_eq("mix_fwd_b_gone", 32'(fwd_b), 32'd0);
        check_eq("mix_cycles", 32'(stall_cycles), 32'd6);

        // Persistent load hazard keeps stalling until the counter saturates.
        tick();
        mem_regwrite = 1'b0;
        mem_rd       = 5'd0;
        ex_regwrite  = 1'b1;
        ex_memtoreg  = 1'b1;
        ex_rd        = 5'd10;
        for (int i = 0; i < 9; i++) tick();
        #2;
        check_stalled("sat_full", 32'd15);
        for (int i = 0; i < 3; i++) tick();
        #2;
        check_stalled("sat_hold", 32'd15);

        // id_branch low in IDLE: nothing happens even with a hazard present.
        tick();
        tick();
        id_branch = 1'b0;
        #2;
        check_eq("nobr_stall", 32'(stall), 32'd0);
        check_eq("nobr_cmp_valid", 32'(cmp_valid), 32'd0);
        check_eq("nobr_pc_src", 32'(pc_src), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
